// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clk_en_pkg;

    // Control FSM states: RUN accepts configuration, SETTLE waits out the lock interval.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } state_e;

    // Working width of clamp_phase; callers cast their ACC_W-wide values in and out (ACC_W <= 64).
    localparam int unsigned CLAMP_W = 64;

    // Accumulator preload value: min(ph, max(den,1)-1), so a preload never sits at or above the modulus.
    function automatic logic [CLAMP_W-1:0] clamp_phase(input logic [CLAMP_W-1:0] ph,
                                                       input logic [CLAMP_W-1:0] den);
        logic [CLAMP_W-1:0] den_eff;
        logic [CLAMP_W-1:0] res;
        if (den == 64'd0) begin
            den_eff = 64'd1;
        end else begin
            den_eff = den;
        end
        if (ph > (den_eff - 64'd1)) begin
            res = den_eff - 64'd1;
        end else begin
            res = ph;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_en_nco.sv
// One fractional-enable channel: ratio registers, phase accumulator, compare and preload.
module clk_en_nco
    import clk_en_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    input  logic [ACC_W-1:0] cfg_phase,
    input  logic             preload,
    output logic             ce
);

    logic [ACC_W-1:0] num_r;
    logic [ACC_W-1:0] den_r;
    logic [ACC_W-1:0] ph_r;
    logic [ACC_W-1:0] acc_r;
    logic             ce_r;

    logic [ACC_W-1:0] den_eff_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W:0]   diff_s;
    logic             hit_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] cfg_pre_s;
    logic [ACC_W-1:0] reg_pre_s;

    // Accumulate step: a zero modulus acts as one, overflow past den saturates at den-1.
    always_comb begin
        den_eff_s = den_r;
        if (den_r == {ACC_W{1'b0}}) begin
            den_eff_s = ACC_W'(1);
        end else begin
            den_eff_s = den_r;
        end
        sum_s  = {1'b0, acc_r} + {1'b0, num_r};
        diff_s = sum_s - {1'b0, den_eff_s};
        hit_s  = (sum_s >= {1'b0, den_eff_s});
        if (hit_s) begin
            if (diff_s >= {1'b0, den_eff_s}) begin
                acc_nxt_s = den_eff_s - ACC_W'(1);
            end else begin
                acc_nxt_s = diff_s[ACC_W-1:0];
            end
        end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
        end
        cfg_pre_s = ACC_W'(clamp_phase(CLAMP_W'(cfg_phase), CLAMP_W'(cfg_den)));
        reg_pre_s = ACC_W'(clamp_phase(CLAMP_W'(ph_r), CLAMP_W'(den_r)));
    end

    // Channel state: a config write wins over a resync preload, which wins over accumulating.
    always_ff @(posedge refclk) begin
        if (rst) begin
            num_r <= {ACC_W{1'b0}};
            den_r <= ACC_W'(1);
            ph_r  <= {ACC_W{1'b0}};
            acc_r <= {ACC_W{1'b0}};
            ce_r  <= 1'b0;
        end else if (cfg_we) begin
            num_r <= cfg_num;
            den_r <= cfg_den;
            ph_r  <= cfg_phase;
            acc_r <= cfg_pre_s;
            ce_r  <= 1'b0;
        end else if (preload) begin
            acc_r <= reg_pre_s;
            ce_r  <= 1'b0;
        end else begin
            acc_r <= acc_nxt_s;
            ce_r  <= hit_s;
        end
    end

    assign ce = ce_r;

endmodule

// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator: CHANNELS independent num/den enable trains,
// runtime reconfiguration, common resync and a PLL-style locked flag.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    input  logic [ACC_W-1:0]    cfg_phase,
    input  logic                resync,
    output logic [CHANNELS-1:0] ce,
    output logic                locked
);

    localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               cfg_ready_r;
    logic               locked_r;
    logic               accept_s;
    logic [CHANNELS-1:0] we_s;

    // A request is taken only while ready is shown, i.e. in RUN.
    assign accept_s = cfg_valid & cfg_ready_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Out-of-range channel numbers match no instance, so they only restart the settle window.
        assign we_s[g] = accept_s & (cfg_ch == CH_W'(g));

        clk_en_nco #(
            .ACC_W(ACC_W)
        ) u_nco (
            .refclk   (refclk),
            .rst      (rst),
            .cfg_we   (we_s[g]),
            .cfg_num  (cfg_num),
            .cfg_den  (cfg_den),
            .cfg_phase(cfg_phase),
            .preload  (resync),
            .ce       (ce[g])
        );
    end

    // Next-state logic: resync always restarts SETTLE; SETTLE counts LOCK_CYCLES cycles then returns to RUN.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (resync) begin
            state_nxt_s = SETTLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (accept_s) begin
                        state_nxt_s = SETTLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = cnt_r;
                    end
                end
                SETTLE: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = SETTLE;
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = SETTLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM, settle counter and registered handshake/lock flags derived from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r     <= SETTLE;
            cnt_r       <= {CNT_W{1'b0}};
            cfg_ready_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cfg_ready_r <= (state_nxt_s == RUN);
            locked_r    <= (state_nxt_s == RUN);
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: per-cycle scoreboard plus directed ratio/phase/handshake checks.
module tb_clk_en_gen;

    localparam int CH = 3;
    localparam int LC = 16;

    logic        refclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_num;
    logic [31:0] cfg_den;
    logic [31:0] cfg_phase;
    logic        resync;
    logic [2:0]  ce;
    logic        locked;

    always #5 refclk = ~refclk;

    clk_en_gen #(
        .CHANNELS   (CH),
        .ACC_W      (32),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .cfg_phase(cfg_phase),
        .resync   (resync),
        .ce       (ce),
        .locked   (locked)
    );

    typedef struct packed {
        logic [2:0] ce;
        logic       rdy;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_num [CH];
    logic [31:0] m_den [CH];
    logic [31:0] m_ph  [CH];
    logic [31:0] m_acc [CH];
    logic [2:0]  m_ce  = 3'b000;
    logic        m_run = 1'b0;
    int          m_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] clampm(input logic [31:0] ph, input logic [31:0] den);
        logic [31:0] d;
        d = (den == 32'd0) ? 32'd1 : den;
        return (ph > d - 32'd1) ? d - 32'd1 : ph;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven; push the expectation.
    task automatic model_step();
        logic [32:0] s;
        logic [31:0] d;
        logic        acc_ok;
        exp_t        e;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_num[i] = 32'd0; m_den[i] = 32'd1; m_ph[i] = 32'd0; m_acc[i] = 32'd0;
            end
            m_ce = 3'b000; m_run = 1'b0; m_cnt = 0;
        end else begin
            acc_ok = cfg_valid && m_run;
            for (int i = 0; i < CH; i++) begin
                if (acc_ok && (int'(cfg_ch) == i)) begin
                    m_num[i] = cfg_num; m_den[i] = cfg_den; m_ph[i] = cfg_phase;
                    m_acc[i] = clampm(cfg_phase, cfg_den);
                    m_ce[i]  = 1'b0;
                end else if (resync) begin
                    m_acc[i] = clampm(m_ph[i], m_den[i]);
                    m_ce[i]  = 1'b0;
                end else begin
                    d = (m_den[i] == 32'd0) ? 32'd1 : m_den[i];
                    s = {1'b0, m_acc[i]} + {1'b0, m_num[i]};
                    if (s >= {1'b0, d}) begin
                        s = s - {1'b0, d};
                        m_acc[i] = (s >= {1'b0, d}) ? d - 32'd1 : s[31:0];
                        m_ce[i]  = 1'b1;
                    end else begin
                        m_acc[i] = s[31:0];
                        m_ce[i]  = 1'b0;
                    end
                end
            end
            if (resync || acc_ok) begin
                m_run = 1'b0; m_cnt = 0;
            end else if (!m_run) begin
                if (m_cnt == LC - 1) begin
                    m_run = 1'b1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        e.ce = m_ce; e.rdy = m_run; e.lk = m_run;
        sb.push_back(e);
    endtask

    // One clock: model, edge, then compare DUT outputs on the falling edge.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge refclk);
        @(negedge refclk);
        e = sb.pop_front();
        check_eq("sb_ce", {29'd0, ce}, {29'd0, e.ce});
        check_eq("sb_cfg_ready", {31'd0, cfg_ready}, {31'd0, e.rdy});
        check_eq("sb_locked", {31'd0, locked}, {31'd0, e.lk});
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !cfg_ready; i++) tick();
        check_eq("wait_ready", {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic wait_locked();
        for (int i = 0; i < 100 && !locked; i++) tick();
        check_eq("wait_locked", {31'd0, locked}, 32'd1);
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [31:0] num,
                          input logic [31:0] den, input logic [31:0] ph);
        wait_ready();
        cfg_ch = ch; cfg_num = num; cfg_den = den; cfg_phase = ph; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic run_count(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]);
        end
    endtask

    initial begin
        int lock_at, rdy_at, pulses, cnt, bad, last, low;
        int f1, f2, s1, s2, c0, c1, c2;

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_num = 32'd0;
        cfg_den = 32'd0; cfg_phase = 32'd0; resync = 1'b0;
        repeat (3) tick();

        // Reset then idle: locked and cfg_ready rise together at cycle LC+1
        rst = 1'b0;
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
        lock_at = 0; rdy_at = 0; pulses = 0;
        for (int k = 2; k <= 30; k++) begin
            tick();
            pulses += $countones(ce);
            if (locked && lock_at == 0) begin
                lock_at = k;
                rdy_at  = int'(cfg_ready);
            end
        end
        check_eq("lock_cycle", lock_at, LC + 1);
        check_eq("ready_at_lock", rdy_at, 32'd1);
        check_eq("idle_ce", pulses, 32'd0);

        // Ratio accuracy 3/8
        do_cfg(2'd0, 32'd3, 32'd8, 32'd0);
        wait_locked();
        cnt = 0; bad = 0; last = -1;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (ce[0]) begin
                cnt++;
                if (last >= 0 && (k - last < 2 || k - last > 3)) bad++;
                last = k;
            end
        end
        check_eq("ratio_count", cnt, 32'd300);
        check_eq("ratio_gaps", bad, 32'd0);

        // Phase alignment: ch2 leads ch1 by 2 cycles, both period 4
        do_cfg(2'd1, 32'd1, 32'd4, 32'd0);
        do_cfg(2'd2, 32'd1, 32'd4, 32'd2);
        wait_ready();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check_eq("resync_ce", {29'd0, ce}, 32'd0);
        f1 = 0; f2 = 0; s1 = 0; s2 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (ce[1]) begin if (f1 == 0) f1 = k; else if (s1 == 0) s1 = k; end
            if (ce[2]) begin if (f2 == 0) f2 = k; else if (s2 == 0) s2 = k; end
        end
        check_eq("ph_ch2_first", f2, 32'd2);
        check_eq("ph_lead", f1 - f2, 32'd2);
        check_eq("ph_per1", s1 - f1, 32'd4);
        check_eq("ph_per2", s2 - f2, 32'd4);

        // Edge ratios
        do_cfg(2'd0, 32'd5, 32'd5, 32'd0);
        do_cfg(2'd1, 32'd0, 32'd7, 32'd3);
        do_cfg(2'd2, 32'd1, 32'd0, 32'd9);
        wait_locked();
        run_count(20, c0, c1, c2);
        check_eq("num_eq_den", c0, 32'd20);
        check_eq("num_zero", c1, 32'd0);
        check_eq("den_zero", c2, 32'd20);

        // Phase beyond modulus clamps to den-1
        wait_ready();
        cfg_ch = 2'd0; cfg_num = 32'd1; cfg_den = 32'd8; cfg_phase = 32'd100; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check_eq("ph100_accept_ce", {31'd0, ce[0]}, 32'd0);
        tick();
        check_eq("ph100_first", {31'd0, ce[0]}, 32'd1);

        // Handshake: valid held 3 cycles, only the first is taken
        wait_ready();
        cfg_ch = 2'd1; cfg_num = 32'd1; cfg_den = 32'd2; cfg_phase = 32'd0; cfg_valid = 1'b1;
        tick();
        check_eq("hs_ready_low", {31'd0, cfg_ready}, 32'd0);
        check_eq("hs_locked_low", {31'd0, locked}, 32'd0);
        cfg_num = 32'd0;
        low = 1;
        for (int i = 0; i < 40; i++) begin
            cfg_valid = (i < 2);
            tick();
            if (cfg_ready) break;
            low++;
        end
        cfg_valid = 1'b0;
        check_eq("hs_low_cycles", low, 32'd16);
        check_eq("hs_relock", {31'd0, locked}, 32'd1);
        run_count(20, c0, c1, c2);
        check_eq("hs_ch1_rate", c1, 32'd10);

        // Out-of-range channel: nothing stored, settle still restarts
        do_cfg(2'd3, 32'd1, 32'd1, 32'd0);
        check_eq("oor_settle", {31'd0, cfg_ready}, 32'd0);
        wait_locked();
        run_count(20, c0, c1, c2);
        check_eq("oor_ch1", c1, 32'd10);
        check_eq("oor_ch2", c2, 32'd20);

        // Reset in the middle of SETTLE
        do_cfg(2'd2, 32'd1, 32'd3, 32'd0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_ready", {31'd0, cfg_ready}, 32'd0);
        check_eq("mrst_locked", {31'd0, locked}, 32'd0);
        check_eq("mrst_ce", {29'd0, ce}, 32'd0);
        wait_locked();
        run_count(20, c0, c1, c2);
        check_eq("mrst_idle", c0 + c1 + c2, 32'd0);

        // Resync coinciding with a config accept: new phase is used
        wait_ready();
        cfg_ch = 2'd2; cfg_num = 32'd1; cfg_den = 32'd4; cfg_phase = 32'd3;
        cfg_valid = 1'b1; resync = 1'b1;
        tick();
        cfg_valid = 1'b0; resync = 1'b0;
        check_eq("rsc_ce", {29'd0, ce}, 32'd0);
        check_eq("rsc_ready", {31'd0, cfg_ready}, 32'd0);
        tick();
        check_eq("rsc_ch2", {29'd0, ce}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
